// File: rtl/femto_bus_arbiter_pkg.sv
// Shared encodings for the two-master femtosoc bus arbiter.
package femto_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/femto_bus_req_latch.sv
// Per-master request capture: pending flag, addr/wdata/wmask/type registers
// and the busy flags the master sees.
module femto_bus_req_latch #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  input  logic                  rstrb,
  input  logic                  issue,
  input  logic                  s_rbusy,
  input  logic                  s_wbusy,
  output logic                  req_ok,
  output logic                  pend,
  output logic                  act_done,
  output logic [ADDR_WIDTH-1:0] sel_addr,
  output logic [31:0]           sel_wdata,
  output logic [3:0]            sel_wmask,
  output logic                  sel_wr,
  output logic [ADDR_WIDTH-1:0] q_addr,
  output logic [31:0]           q_wdata,
  output logic                  rbusy,
  output logic                  wbusy
);

  logic       live_wr, live_req;
  logic       act, wr_q;
  logic [3:0] wmask_q;

  // A write mask wins over a simultaneous read strobe.
  assign live_wr  = |wmask;
  assign live_req = rstrb | live_wr;

  // Strobes from a master that already has something queued or on the bus are dropped.
  assign req_ok   = live_req & ~pend & ~act;

  // The slave finishes the owner's access in the first non-busy cycle after issue.
  assign act_done = act & (wr_q ? ~s_wbusy : ~s_rbusy);

  // What would go to the slave if this master were issued this cycle.
  assign sel_addr  = pend ? q_addr  : addr;
  assign sel_wdata = pend ? q_wdata : wdata;
  assign sel_wmask = pend ? wmask_q : wmask;
  assign sel_wr    = pend ? wr_q    : live_wr;

  // Busy while queued, then mirror the slave while our access is in flight.
  assign rbusy = ~wr_q & (pend | (act & s_rbusy));
  assign wbusy =  wr_q & (pend | (act & s_wbusy));

  // Capture on a live issue (so addr stays stable) or when the request must wait.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend    <= 1'b0;
      act     <= 1'b0;
      wr_q    <= 1'b0;
      wmask_q <= '0;
      q_addr  <= '0;
      q_wdata <= '0;
    end else begin
      if (act_done) act <= 1'b0;
      if (issue) begin
        act  <= 1'b1;
        pend <= 1'b0;
        if (!pend) begin
          q_addr  <= addr;
          q_wdata <= wdata;
          wmask_q <= wmask;
          wr_q    <= live_wr;
        end
      end else if (req_ok) begin
        pend    <= 1'b1;
        q_addr  <= addr;
        q_wdata <= wdata;
        wmask_q <= wmask;
        wr_q    <= live_wr;
      end
    end
  end

endmodule

// File: rtl/femto_bus_arbiter.sv
// Two-master arbiter for the femtosoc strobe bus: FSM, round-robin pointer
// and slave-side muxing. Addresses are held stable for the combinational rdata mux.
module femto_bus_arbiter
  import femto_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_rstrb,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rbusy,
  output logic                  m0_wbusy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_rstrb,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rbusy,
  output logic                  m1_wbusy,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wmask,
  output logic                  s_rstrb,
  input  logic [31:0]           s_rdata,
  input  logic                  s_rbusy,
  input  logic                  s_wbusy,
  output logic [1:0]            s_owner
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d, win;
  logic   last_m1_q, last_m1_d;

  logic                  ok0, ok1, pend0, pend1, done0, done1;
  logic [ADDR_WIDTH-1:0] sa0, sa1, qa0, qa1;
  logic [31:0]           sd0, sd1, qd0, qd1;
  logic [3:0]            sm0, sm1;
  logic                  sw0, sw1;

  femto_bus_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_m0 (
    .clk(clk), .resetn(resetn),
    .addr(m0_addr), .wdata(m0_wdata), .wmask(m0_wmask), .rstrb(m0_rstrb),
    .issue(win == OWN_M0), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .req_ok(ok0), .pend(pend0), .act_done(done0),
    .sel_addr(sa0), .sel_wdata(sd0), .sel_wmask(sm0), .sel_wr(sw0),
    .q_addr(qa0), .q_wdata(qd0), .rbusy(m0_rbusy), .wbusy(m0_wbusy)
  );

  femto_bus_req_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_m1 (
    .clk(clk), .resetn(resetn),
    .addr(m1_addr), .wdata(m1_wdata), .wmask(m1_wmask), .rstrb(m1_rstrb),
    .issue(win == OWN_M1), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .req_ok(ok1), .pend(pend1), .act_done(done1),
    .sel_addr(sa1), .sel_wdata(sd1), .sel_wmask(sm1), .sel_wr(sw1),
    .q_addr(qa1), .q_wdata(qd1), .rbusy(m1_rbusy), .wbusy(m1_wbusy)
  );

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign s_owner  = owner_q;

  // Winner selection in IDLE: a lone pending request beats live strobes,
  // otherwise ties go to M0 (fixed) or away from the last winner.
  always_comb begin
    win = OWN_NONE;
    if (state_q == ST_IDLE) begin
      if (pend0 && !pend1)                 win = OWN_M0;
      else if (pend1 && !pend0)            win = OWN_M1;
      else if ((pend0 | ok0) && (pend1 | ok1))
        win = ((FIXED_PRIO != 0) || last_m1_q) ? OWN_M0 : OWN_M1;
      else if (ok0)                        win = OWN_M0;
      else if (ok1)                        win = OWN_M1;
    end
  end

  // Next state: grant moves to ACTIVE, slave completion returns to IDLE.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_m1_d = last_m1_q;
    case (state_q)
      ST_IDLE: if (win != OWN_NONE) begin
        state_d   = ST_ACTIVE;
        owner_d   = win;
        last_m1_d = (win == OWN_M1);
      end
      ST_ACTIVE: if (done0 | done1) begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slave side: strobes only in the grant cycle, latched owner values afterwards.
  // Strobes are gated by reset so nothing leaks to the slave while held in reset.
  always_comb begin
    s_rstrb = 1'b0;
    s_wmask = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (win == OWN_M0) begin
      s_rstrb = resetn & ~sw0;
      s_wmask = resetn ? sm0 : 4'b0000;
      s_addr  = sa0;
      s_wdata = sd0;
    end else if (win == OWN_M1) begin
      s_rstrb = resetn & ~sw1;
      s_wmask = resetn ? sm1 : 4'b0000;
      s_addr  = sa1;
      s_wdata = sd1;
    end else if (owner_q == OWN_M0) begin
      s_addr  = qa0;
      s_wdata = qd0;
    end else if (owner_q == OWN_M1) begin
      s_addr  = qa1;
      s_wdata = qd1;
    end
  end

  // State, owner and round-robin pointer (reset to "last=M1" so M0 wins the first tie).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_m1_q <= last_m1_d;
    end
  end

endmodule

// File: tb/tb_femto_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the
// same stimulus and are both compared against a transaction-level model.
module tb_femto_bus_arbiter;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata, s_rdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic          m0_rstrb, m1_rstrb, s_rbusy, s_wbusy;

  logic [31:0]   m0_rdata [2];
  logic [31:0]   m1_rdata [2];
  logic          m0_rbusy [2];
  logic          m1_rbusy [2];
  logic          m0_wbusy [2];
  logic          m1_wbusy [2];
  logic [AW-1:0] s_addr   [2];
  logic [31:0]   s_wdata  [2];
  logic [3:0]    s_wmask  [2];
  logic          s_rstrb  [2];
  logic [1:0]    s_owner  [2];

  femto_bus_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata[0]), .m0_rbusy(m0_rbusy[0]), .m0_wbusy(m0_wbusy[0]),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata[0]), .m1_rbusy(m1_rbusy[0]), .m1_wbusy(m1_wbusy[0]),
    .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wmask(s_wmask[0]), .s_rstrb(s_rstrb[0]),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .s_owner(s_owner[0])
  );

  femto_bus_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata[1]), .m0_rbusy(m0_rbusy[1]), .m0_wbusy(m0_wbusy[1]),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata[1]), .m1_rbusy(m1_rbusy[1]), .m1_wbusy(m1_wbusy[1]),
    .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wmask(s_wmask[1]), .s_rstrb(s_rstrb[1]),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .s_owner(s_owner[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one queued request per master, one on the bus.
  typedef struct packed {
    logic          v;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
  } tx_t;

  tx_t pend [2][2];
  tx_t cur  [2];
  tx_t src  [2];
  tx_t live [2];
  int  own  [2];
  int  last [2];
  int  win  [2];
  bit  ok   [2][2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend[d][0] = '0; pend[d][1] = '0; cur[d] = '0;
      own[d] = -1; last[d] = 1; win[d] = -1;
    end
  endtask

  function automatic int tie(input int d);
    if (d == 1) return 0;
    return (last[d] == 1) ? 0 : 1;
  endfunction

  // Drive one cycle of inputs, then compare both DUTs against the model.
  task automatic cyc(input bit r0, input logic [3:0] w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                     input bit r1, input logic [3:0] w1, input logic [AW-1:0] a1, input logic [31:0] d1,
                     input bit rb, input bit wb, input logic [31:0] rd);
    bit exp_rb [2];
    bit exp_wb [2];
    int np;
    m0_rstrb = r0; m0_wmask = w0; m0_addr = a0; m0_wdata = d0;
    m1_rstrb = r1; m1_wmask = w1; m1_addr = a1; m1_wdata = d1;
    s_rbusy = rb; s_wbusy = wb; s_rdata = rd;
    live[0] = '{v: r0 | (w0 != 0), wr: (w0 != 0), addr: a0, wdata: d0, wmask: w0};
    live[1] = '{v: r1 | (w1 != 0), wr: (w1 != 0), addr: a1, wdata: d1, wmask: w1};
    #2;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) ok[d][k] = live[k].v && !pend[d][k].v && own[d] != k;
      win[d] = -1;
      if (own[d] < 0) begin
        np = int'(pend[d][0].v) + int'(pend[d][1].v);
        if (np == 1)                     win[d] = pend[d][0].v ? 0 : 1;
        else if (np == 2)                win[d] = tie(d);
        else if (ok[d][0] && ok[d][1])   win[d] = tie(d);
        else if (ok[d][0])               win[d] = 0;
        else if (ok[d][1])               win[d] = 1;
      end
      if (win[d] >= 0) begin
        src[d] = pend[d][win[d]].v ? pend[d][win[d]] : live[win[d]];
        chk($sformatf("d%0d s_rstrb", d), 64'(s_rstrb[d]), 64'(!src[d].wr));
        chk($sformatf("d%0d s_wmask", d), 64'(s_wmask[d]), src[d].wr ? 64'(src[d].wmask) : 64'd0);
        chk($sformatf("d%0d s_addr issue", d), 64'(s_addr[d]), 64'(src[d].addr));
        chk($sformatf("d%0d s_wdata issue", d), 64'(s_wdata[d]), 64'(src[d].wdata));
      end else begin
        chk($sformatf("d%0d s_rstrb", d), 64'(s_rstrb[d]), 64'd0);
        chk($sformatf("d%0d s_wmask", d), 64'(s_wmask[d]), 64'd0);
        if (own[d] >= 0) begin
          chk($sformatf("d%0d s_addr hold", d), 64'(s_addr[d]), 64'(cur[d].addr));
          chk($sformatf("d%0d s_wdata hold", d), 64'(s_wdata[d]), 64'(cur[d].wdata));
        end
      end
      chk($sformatf("d%0d s_owner", d), 64'(s_owner[d]), (own[d] < 0) ? 64'd0 : 64'(own[d] + 1));
      for (int k = 0; k < 2; k++) begin
        exp_rb[k] = (pend[d][k].v && !pend[d][k].wr) || (own[d] == k && !cur[d].wr && rb);
        exp_wb[k] = (pend[d][k].v &&  pend[d][k].wr) || (own[d] == k &&  cur[d].wr && wb);
      end
      chk($sformatf("d%0d m0_rbusy", d), 64'(m0_rbusy[d]), 64'(exp_rb[0]));
      chk($sformatf("d%0d m1_rbusy", d), 64'(m1_rbusy[d]), 64'(exp_rb[1]));
      chk($sformatf("d%0d m0_wbusy", d), 64'(m0_wbusy[d]), 64'(exp_wb[0]));
      chk($sformatf("d%0d m1_wbusy", d), 64'(m1_wbusy[d]), 64'(exp_wb[1]));
      chk($sformatf("d%0d m0_rdata", d), 64'(m0_rdata[d]), 64'(rd));
      chk($sformatf("d%0d m1_rdata", d), 64'(m1_rdata[d]), 64'(rd));
    end
  endtask

  // Advance the model past the coming clock edge, then move to just after it.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (own[d] >= 0 && (cur[d].wr ? !s_wbusy : !s_rbusy)) begin
        own[d] = -1;
      end else if (win[d] >= 0) begin
        own[d] = win[d]; cur[d] = src[d]; last[d] = win[d];
        pend[d][win[d]].v = 1'b0;
      end
      for (int k = 0; k < 2; k++) if (ok[d][k] && win[d] != k) pend[d][k] = live[k];
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rb, input bit wb);
    cyc(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, rb, wb, 32'h0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d owner", tag, d), 64'(s_owner[d]), 64'd0);
      chk($sformatf("%s d%0d rstrb", tag, d), 64'(s_rstrb[d]), 64'd0);
      chk($sformatf("%s d%0d wmask", tag, d), 64'(s_wmask[d]), 64'd0);
      chk($sformatf("%s d%0d busy", tag, d),
          64'({m0_rbusy[d], m1_rbusy[d], m0_wbusy[d], m1_wbusy[d]}), 64'd0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    m0_rstrb = 0; m1_rstrb = 0; m0_wmask = 0; m1_wmask = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    s_rdata = 0; s_rbusy = 0; s_wbusy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    resetn = 1'b1;

    // Simultaneous reads from reset: M0 first, M1 queued and served next.
    cyc(1, 4'h0, 24'h000100, '0, 1, 4'h0, 24'h000200, '0, 0, 0, 32'h0);
    chk("rr0 s_addr c0", 64'(s_addr[0]), 64'h100);
    tick();
    cyc(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 0, 0, 32'h11111111);
    chk("rr0 m1_rbusy c1", 64'(m1_rbusy[0]), 64'd1);
    tick();
    cyc(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 0, 0, 32'h0);
    chk("rr0 s_rstrb c2", 64'(s_rstrb[0]), 64'd1);
    chk("rr0 s_addr c2", 64'(s_addr[0]), 64'h200);
    tick();
    cyc(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 0, 0, 32'h22222222);
    chk("rr0 m1_rdata c3", 64'(m1_rdata[0]), 64'h22222222);
    tick();

    // Single M0 read on an idle bus: zero-latency issue, data next cycle.
    cyc(1, 4'h0, 24'h000010, '0, 0, 4'h0, '0, '0, 0, 0, 32'h0);
    chk("single s_rstrb c0", 64'(s_rstrb[0]), 64'd1);
    tick();
    cyc(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 0, 0, 32'hDEADBEEF);
    chk("single m0_rbusy c1", 64'(m0_rbusy[0]), 64'd0);
    chk("single m0_rdata c1", 64'(m0_rdata[0]), 64'hDEADBEEF);
    chk("single s_owner c1", 64'(s_owner[0]), 64'd1);
    tick();

    // Same simultaneous pair again: pointer now favours M1; fixed prio still M0.
    cyc(1, 4'h0, 24'h000100, '0, 1, 4'h0, 24'h000200, '0, 0, 0, 32'h0);
    chk("rr1 s_addr c0", 64'(s_addr[0]), 64'h200);
    chk("fp1 s_addr c0", 64'(s_addr[1]), 64'h100);
    tick();
    repeat (3) idle(0, 0);

    // Slow flash read by M1 with an M0 write arriving mid-flight.
    for (int c = 0; c < 10; c++) begin
      cyc(0, (c == 2) ? 4'hF : 4'h0, 24'h000040, 32'hCAFEF00D,
          c == 0, 4'h0, 24'h820000, '0, (c >= 1 && c <= 5), 0, 32'h0);
      if (c == 3) chk("flash m0_wbusy c3", 64'(m0_wbusy[0]), 64'd1);
      if (c == 6) chk("flash s_addr c6", 64'(s_addr[0]), 64'h820000);
      if (c == 7) begin
        chk("flash s_wmask c7", 64'(s_wmask[0]), 64'hF);
        chk("flash s_addr c7", 64'(s_addr[0]), 64'h40);
        chk("flash m0_wbusy c7", 64'(m0_wbusy[0]), 64'd1);
      end
      tick();
    end

    // Write held busy by the slave for two cycles.
    for (int c = 0; c < 5; c++) begin
      cyc(0, (c == 0) ? 4'h3 : 4'h0, 24'h000044, 32'h0000ABCD,
          0, 4'h0, '0, '0, 0, (c == 1 || c == 2), 32'h0);
      if (c == 0) chk("wr s_wmask c0", 64'(s_wmask[0]), 64'h3);
      if (c == 1) chk("wr s_wmask c1", 64'(s_wmask[0]), 64'h0);
      if (c == 1 || c == 2) chk($sformatf("wr m0_wbusy c%0d", c), 64'(m0_wbusy[0]), 64'd1);
      if (c == 3) chk("wr m0_wbusy c3", 64'(m0_wbusy[0]), 64'd0);
      tick();
    end

    // Randomized traffic, including a reset in the middle of a transaction.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        while (!(own[0] >= 0 && pend[0][1].v)) begin
          cyc(1, 4'h0, 24'($urandom), $urandom, 1, 4'h0, 24'($urandom), $urandom, 1, 1, $urandom);
          tick();
        end
        m0_rstrb = 1'b1; m1_wmask = 4'hF;
        #1 resetn = 1'b0;
        #1;
        check_reset_vals("midreset");
        model_reset();
        @(posedge clk); #1;
        m0_rstrb = 1'b0; m1_wmask = 4'h0;
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
          cyc(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 0, 0, 32'h0);
          chk("post-reset s_rstrb", 64'(s_rstrb[0]), 64'd0);
          tick();
        end
      end
      cyc($urandom_range(0, 3) == 0, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
          24'($urandom), $urandom,
          $urandom_range(0, 3) == 0, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
          24'($urandom), $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
